// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sequential ALU: alu_op and func codes, 4-bit control code, FSM states.
// The low three control bits keep the legacy alu_ctr values so the old control path can reuse them.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_XOR   = 6'b101010;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MULTU = 6'b011000;
  localparam logic [5:0] FUNC_DIVU  = 6'b011010;

  typedef enum logic [3:0] {
    CTL_AND  = 4'b0000,
    CTL_OR   = 4'b0001,
    CTL_ADD  = 4'b0010,
    CTL_XOR  = 4'b0011,
    CTL_SUB  = 4'b0110,
    CTL_MUL  = 4'b1000,
    CTL_DIV  = 4'b1001,
    CTL_MFHI = 4'b1010,
    CTL_MFLO = 4'b1011
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle between the EX-stage control FSM (master) and the ALU unit (slave).
// in_valid/in_ready gate acceptance; out_valid is a one-cycle pulse qualifying result and flags.
interface alu_seq_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            alu_op;
  logic [5:0]            func;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;
  logic                  out_valid;
  logic                  illegal;
  logic                  div_by_zero;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  busy;

  modport master (
    output in_valid, alu_op, func, a, b,
    input  in_ready, result, zero, out_valid, illegal, div_by_zero, hi, lo, busy
  );

  modport slave (
    input  in_valid, alu_op, func, a, b,
    output in_ready, result, zero, out_valid, illegal, div_by_zero, hi, lo, busy
  );
endinterface

// File: rtl/alu_seq_decode.sv
// Combinational alu_op/func decode into the 4-bit control code plus an illegal-func flag.
// No state, no handshake; unknown R-type funcs return CTL_AND with illegal_o set.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] func_i,
  output alu_ctl_e   ctl_o,
  output logic       illegal_o
);

  always_comb begin
    ctl_o     = CTL_AND;
    illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: ctl_o = CTL_ADD;
      ALUOP_SUB: ctl_o = CTL_SUB;
      ALUOP_OR:  ctl_o = CTL_OR;
      default: begin
        case (func_i)
          FUNC_ADD:   ctl_o = CTL_ADD;
          FUNC_SUB:   ctl_o = CTL_SUB;
          FUNC_AND:   ctl_o = CTL_AND;
          FUNC_OR:    ctl_o = CTL_OR;
          FUNC_XOR:   ctl_o = CTL_XOR;
          FUNC_MFHI:  ctl_o = CTL_MFHI;
          FUNC_MFLO:  ctl_o = CTL_MFLO;
          FUNC_MULTU: ctl_o = CTL_MUL;
          FUNC_DIVU:  ctl_o = CTL_DIV;
          default:    illegal_o = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// EX-stage ALU: single-cycle ops answer 1 cycle after accept; multu/divu iterate and answer after DATA_WIDTH+1.
// in_ready is high only in IDLE; requests seen while busy are dropped, never queued.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_unit_if.slave bus
);

  localparam int                   CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] wrk_q, wrk_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic                  zero_q, zero_d;
  logic                  out_valid_q, out_valid_d;
  logic                  illegal_q, illegal_d;
  logic                  dbz_q, dbz_d;

  alu_ctl_e              ctl;
  logic                  dec_illegal;
  logic                  accept;

  logic [DATA_WIDTH:0]   add_x, add_y;
  logic                  add_sub;
  logic [DATA_WIDTH+1:0] add_sum;
  logic [DATA_WIDTH:0]   mul_sel;
  logic                  div_q;

  alu_seq_decode u_decode (
    .alu_op_i  (bus.alu_op),
    .func_i    (bus.func),
    .ctl_o     (ctl),
    .illegal_o (dec_illegal)
  );

  assign accept = bus.in_valid && (state_q == ST_IDLE);

  // One adder serves IDLE add/sub, the multiply accumulate and the divide trial subtraction.
  always_comb begin
    add_x   = {1'b0, bus.a};
    add_y   = {1'b0, bus.b};
    add_sub = (ctl == CTL_SUB);
    case (state_q)
      ST_MUL: begin
        add_x   = {1'b0, acc_q};
        add_y   = {1'b0, dvs_q};
        add_sub = 1'b0;
      end
      ST_DIV: begin
        add_x   = {acc_q, wrk_q[DATA_WIDTH-1]};
        add_y   = {1'b0, dvs_q};
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, add_x} + {1'b0, (add_sub ? ~add_y : add_y)}
                 + {{(DATA_WIDTH+1){1'b0}}, add_sub};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    wrk_d       = wrk_q;
    dvs_d       = dvs_q;
    result_d    = result_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    illegal_d   = 1'b0;
    dbz_d       = 1'b0;
    mul_sel     = wrk_q[0] ? add_sum[DATA_WIDTH:0] : {1'b0, acc_q};
    // Carry out of the subtraction means the shifted remainder covers the divisor.
    div_q       = add_sum[DATA_WIDTH+1];

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          case (ctl)
            CTL_AND:          result_d = bus.a & bus.b;
            CTL_OR:           result_d = bus.a | bus.b;
            CTL_XOR:          result_d = bus.a ^ bus.b;
            CTL_ADD, CTL_SUB: result_d = add_sum[DATA_WIDTH-1:0];
            CTL_MFHI:         result_d = hi_q;
            CTL_MFLO:         result_d = lo_q;
            CTL_MUL: begin
              state_d     = ST_MUL;
              out_valid_d = 1'b0;
              cnt_d       = '0;
              acc_d       = '0;
              wrk_d       = bus.a;
              dvs_d       = bus.b;
            end
            CTL_DIV: begin
              if (bus.b == '0) begin
                result_d = '1;
                lo_d     = '1;
                hi_d     = bus.a;
                dbz_d    = 1'b1;
              end else begin
                state_d     = ST_DIV;
                out_valid_d = 1'b0;
                cnt_d       = '0;
                acc_d       = '0;
                wrk_d       = bus.a;
                dvs_d       = bus.b;
              end
            end
            default: ;
          endcase
          if (dec_illegal) begin
            result_d  = '0;
            illegal_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        acc_d = mul_sel[DATA_WIDTH:1];
        wrk_d = {mul_sel[0], wrk_q[DATA_WIDTH-1:1]};
      end
      ST_DIV: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        acc_d = div_q ? add_sum[DATA_WIDTH-1:0]
                      : {acc_q[DATA_WIDTH-2:0], wrk_q[DATA_WIDTH-1]};
        wrk_d = {wrk_q[DATA_WIDTH-2:0], div_q};
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_MUL || state_q == ST_DIV) && cnt_d == CNT_LAST) begin
      state_d     = ST_IDLE;
      hi_d        = acc_d;
      lo_d        = wrk_d;
      result_d    = wrk_d;
      out_valid_d = 1'b1;
    end

    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      wrk_q       <= '0;
      dvs_q       <= '0;
      result_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      wrk_q       <= wrk_d;
      dvs_q       <= dvs_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.result      = result_q;
  assign bus.zero        = zero_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.illegal     = illegal_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: decode table applied back-to-back, then hand-written multu/divu/reset sequences.
// Expected responses are queued at issue time and checked when out_valid pulses.
module tb_alu_seq_unit;
  import alu_seq_pkg::*;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_unit_if #(.DATA_WIDTH(DW)) bus_if ();

  alu_seq_unit #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic          ill;
    logic          dbz;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    int            lat;
    int            cyc0;
  } exp_t;

  typedef struct {
    logic [1:0]    op;
    logic [5:0]    fn;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
  } vec_t;

  exp_t          exp_q[$];
  int            n_cmp  = 0;
  int            n_err  = 0;
  int            cyc    = 0;
  int            ov_cnt = 0;
  logic [DW-1:0] m_hi   = '0;
  logic [DW-1:0] m_lo   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus_if.out_valid) begin
      ov_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out_valid: got out_valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("result",      64'(bus_if.result),      64'(e.res));
        chk("zero",        64'(bus_if.zero),        64'(e.res == '0));
        chk("illegal",     64'(bus_if.illegal),     64'(e.ill));
        chk("div_by_zero", 64'(bus_if.div_by_zero), 64'(e.dbz));
        chk("hi",          64'(bus_if.hi),          64'(e.hi));
        chk("lo",          64'(bus_if.lo),          64'(e.lo));
        chk("latency",     64'(cyc - e.cyc0),       64'(e.lat));
      end
    end
  end

  task automatic expect_op(input logic [DW-1:0] res, input logic ill, input logic dbz,
                           input logic [DW-1:0] hi, input logic [DW-1:0] lo, input int lat);
    exp_t e;
    e.res  = res;
    e.ill  = ill;
    e.dbz  = dbz;
    e.hi   = hi;
    e.lo   = lo;
    e.lat  = lat;
    e.cyc0 = cyc;
    m_hi   = hi;
    m_lo   = lo;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus_if.in_valid = 1'b1;
    bus_if.alu_op   = op;
    bus_if.func     = fn;
    bus_if.a        = a;
    bus_if.b        = b;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vec_t vecs[12];
    int   ov_snap;

    vecs[0]  = '{2'b00, 6'h3F,       32'h0000000F, 32'h00000003, 32'h00000012};
    vecs[1]  = '{2'b01, 6'h00,       32'h0000000F, 32'h00000003, 32'h0000000C};
    vecs[2]  = '{2'b11, 6'h2A,       32'h0000000F, 32'h00000003, 32'h0000000F};
    vecs[3]  = '{2'b10, FUNC_ADD,    32'h0000000F, 32'h00000003, 32'h00000012};
    vecs[4]  = '{2'b10, FUNC_SUB,    32'h0000000F, 32'h00000003, 32'h0000000C};
    vecs[5]  = '{2'b10, FUNC_AND,    32'h0000000F, 32'h00000003, 32'h00000003};
    vecs[6]  = '{2'b10, FUNC_OR,     32'h0000000F, 32'h00000003, 32'h0000000F};
    vecs[7]  = '{2'b10, FUNC_XOR,    32'h0000000F, 32'h00000003, 32'h0000000C};
    vecs[8]  = '{2'b01, 6'h22,       32'h00000005, 32'h00000005, 32'h00000000};
    vecs[9]  = '{2'b00, 6'h00,       32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[10] = '{2'b10, FUNC_SUB,    32'h00000000, 32'h00000001, 32'hFFFFFFFF};
    vecs[11] = '{2'b10, FUNC_XOR,    32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0};

    rst_n           = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.alu_op   = 2'b00;
    bus_if.func     = 6'h00;
    bus_if.a        = '0;
    bus_if.b        = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result",    64'(bus_if.result),      64'd0);
    chk("rst_zero",      64'(bus_if.zero),        64'd1);
    chk("rst_out_valid", 64'(bus_if.out_valid),   64'd0);
    chk("rst_illegal",   64'(bus_if.illegal),     64'd0);
    chk("rst_dbz",       64'(bus_if.div_by_zero), 64'd0);
    chk("rst_hi",        64'(bus_if.hi),          64'd0);
    chk("rst_lo",        64'(bus_if.lo),          64'd0);
    chk("rst_busy",      64'(bus_if.busy),        64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus_if.in_ready), 64'd1);

    // Decode table, one request every cycle.
    for (int i = 0; i < 12; i++) begin
      expect_op(vecs[i].res, 1'b0, 1'b0, m_hi, m_lo, 1);
      issue(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
    end
    drain();

    // multu with a full-width product, then mfhi/mflo issued from the out_valid cycle.
    expect_op(32'hFFFFFFFE, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFE, 33);
    issue(2'b10, FUNC_MULTU, 32'hFFFFFFFF, 32'h00000002);
    chk("mul_in_ready_busy", 64'(bus_if.in_ready), 64'd0);
    for (int k = 2; k <= 32; k++) begin
      @(posedge clk);
      #1;
      chk("mul_in_ready_busy", 64'(bus_if.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    chk("mul_in_ready_done", 64'(bus_if.in_ready), 64'd1);
    expect_op(32'h00000001, 1'b0, 1'b0, m_hi, m_lo, 1);
    issue(2'b10, FUNC_MFHI, 32'h0, 32'h0);
    expect_op(32'hFFFFFFFE, 1'b0, 1'b0, m_hi, m_lo, 1);
    issue(2'b10, FUNC_MFLO, 32'h0, 32'h0);
    drain();

    // Reset at cycle 10 of a multu: abort with no response.
    issue(2'b10, FUNC_MULTU, 32'h00000003, 32'h00000005);
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy_before", 64'(bus_if.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    ov_snap = ov_cnt;
    m_hi    = '0;
    m_lo    = '0;
    chk("abort_hi",       64'(bus_if.hi),        64'd0);
    chk("abort_lo",       64'(bus_if.lo),        64'd0);
    chk("abort_in_ready", 64'(bus_if.in_ready),  64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_out_valid", 64'(ov_cnt),          64'(ov_snap));
    chk("abort_ready_after",  64'(bus_if.in_ready), 64'd1);
    chk("abort_busy_after",   64'(bus_if.busy),     64'd0);

    // divu 100/7 with requests pulsed while busy; none may be accepted.
    expect_op(32'd14, 1'b0, 1'b0, 32'd2, 32'd14, 33);
    issue(2'b10, FUNC_DIVU, 32'd100, 32'd7);
    for (int k = 0; k < 3; k++) begin
      chk("div_in_ready_busy", 64'(bus_if.in_ready), 64'd0);
      issue(2'b00, 6'h20, 32'h00000001, 32'h00000001);
      @(posedge clk);
      #1;
    end
    drain();

    expect_op(32'h0FFFFFFF, 1'b0, 1'b0, 32'h0000000F, 32'h0FFFFFFF, 33);
    issue(2'b10, FUNC_DIVU, 32'hFFFFFFFF, 32'h00000010);
    drain();

    // Divide by zero, then an illegal func that must leave hi/lo alone.
    expect_op(32'hFFFFFFFF, 1'b0, 1'b1, 32'h00001234, 32'hFFFFFFFF, 1);
    issue(2'b10, FUNC_DIVU, 32'h00001234, 32'h00000000);
    expect_op(32'h00000000, 1'b1, 1'b0, m_hi, m_lo, 1);
    issue(2'b10, 6'b111111, 32'h0000000F, 32'h00000003);
    drain();

    // multu whose low word is zero: zero flag set by a multi-cycle result.
    expect_op(32'h00000000, 1'b0, 1'b0, 32'h00000001, 32'h00000000, 33);
    issue(2'b10, FUNC_MULTU, 32'h00010000, 32'h00010000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised successor to the combinational ALU-control decoder. Decodes alu_op/func, executes the operation, and adds iterative unsigned multiply/divide with HI/LO registers.
- Sits in the EX stage of the multicycle datapath. Single-cycle ops complete in 1 clock; mult/div stall the control FSM through a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, operand/result width (>=4).
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept request (high only in IDLE)
- alu_op  input  2  00 add(lw/sw), 01 sub(beq/bne), 11 or(ori), 10 R-type by func
- func  input  6  R-type function field
- a  input  DATA_WIDTH  operand A (rs)
- b  input  DATA_WIDTH  operand B (rt/imm)
- result  output  DATA_WIDTH  registered result
- zero  output  1  result==0, registered with result
- out_valid  output  1  one-cycle pulse: result/zero/flags valid
- illegal  output  1  unknown func on accepted R-type, valid with out_valid
- div_by_zero  output  1  divide with b==0, valid with out_valid
- hi  output  DATA_WIDTH  HI register
- lo  output  DATA_WIDTH  LO register
- busy  output  1  mult/div in progress (= !in_ready)

Behaviour:
- Reset (async, rst_n=0): FSM->IDLE; result, hi, lo = 0; zero=1; out_valid, illegal, div_by_zero, busy = 0; in_ready=1 one settle after reset release (combinational from state).
- Accept on rising clk when in_valid & in_ready; a, b, alu_op, func captured. Requests while busy are ignored (no queueing).
- Decode: alu_op 00 add, 01 sub, 11 or.
- R-type func: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 xor, 010000 mfhi, 010010 mflo, 011000 multu, 011010 divu.
- Any other func: result=0, zero=1, illegal=1, 1-cycle latency, HI/LO untouched.
- Internal control code: 4-bit; low 3 bits keep the legacy alu_ctr encoding (and 000, or 001, add 010, sub 110, xor 011); mult 1000, div 1001, mfhi 1010, mflo 1011.
- Single-cycle ops (incl. mfhi/mflo): result registered at the accept edge; out_valid high the following cycle; FSM stays IDLE. Back-to-back accepts every cycle are legal.
- Add/sub wrap modulo 2^DATA_WIDTH; no overflow trap.
- States: IDLE, MUL, DIV. IDLE->MUL on accepted multu; IDLE->DIV on accepted divu with b!=0; MUL/DIV->IDLE when counter reaches DATA_WIDTH.
- multu: shift-add, one bit per cycle, DATA_WIDTH iterations. Full 2*DATA_WIDTH product: {hi,lo}. Final edge updates hi/lo; result=lo; out_valid pulses next cycle. Accept-to-out_valid latency = DATA_WIDTH+1 cycles.
- divu: restoring, one quotient bit per cycle, DATA_WIDTH iterations. lo=quotient, hi=remainder, result=quotient. Same latency as multu.
- divu with b==0: no DIV entry. 1-cycle latency: lo=all ones, hi=a, result=all ones, div_by_zero=1.
- hi/lo change only at completion of mult/div; intermediate working registers are internal.
- in_ready returns high in the cycle out_valid pulses, so a new request can be accepted then.
- Reset mid-operation aborts: IDLE, hi/lo=0, no out_valid.

Decomposition:
- Package alu_seq_pkg: alu_op codes, func codes, 4-bit internal control encoding, state enum.
- One sub-module natural: alu_seq_decode (combinational alu_op/func -> control code + illegal), reusable by the legacy control path.
- Mul/div datapath stays inline, sharing one adder/subtractor and one counter.

Test Plan:
- Reset mid-multu (assert rst_n=0 at cycle 10) -> IDLE, hi=lo=0, no out_valid, in_ready=1 after release.
- Legacy decode sweep (00/any, 01/any, 11/any, 10 with 100000/100010/100100/100101/101010), a=0x0000000F, b=0x00000003:
  - results 0x12, 0xC, 0xF, 0x12, 0xC, 0x3, 0xF, 0xC respectively; out_valid 1 cycle after each accept; back-to-back every cycle.
  - sub with a=b=5 -> zero=1.
- multu a=0xFFFFFFFF, b=0x00000002:
  - out_valid exactly 33 cycles after accept; hi=0x00000001, lo=0xFFFFFFFE; in_ready low for cycles 1..32.
  - then mfhi -> result 0x1.
- divu a=100, b=7 -> lo=14, hi=2, result=14 after 33 cycles; in_valid pulses during busy are ignored.
- divu a=0x1234, b=0 -> next cycle: div_by_zero=1, lo=0xFFFFFFFF, hi=0x1234.
- alu_op=10, func=111111 -> illegal=1, result=0, zero=1, hi/lo unchanged.
